// File: rtl/ccip_host_mem_model_pkg.sv
// rtl/ccip_host_mem_model_pkg.sv - CCI-P subset types and response FIFO entries for the host memory model
package ccip_host_mem_model_pkg;

  localparam int CCIP_ADDR_W  = 42;
  localparam int CCIP_MDATA_W = 16;
  localparam int CCIP_CL_W    = 512;

  localparam int DEFAULT_ADDR_BITS      = 10;
  localparam int DEFAULT_RSP_FIFO_DEPTH = 32;
  localparam int DEFAULT_ALMFULL_SLACK  = 8;

  typedef logic [CCIP_ADDR_W-1:0]  t_ccip_clAddr;
  typedef logic [CCIP_MDATA_W-1:0] t_ccip_mdata;
  typedef logic [CCIP_CL_W-1:0]    t_ccip_clData;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  // Read response FIFO entry: everything needed to rebuild the c0 response header plus the line
  typedef struct packed {
    t_ccip_vc     vc;
    t_ccip_mdata  mdata;
    t_ccip_clData data;
  } t_c0RspEntry;

  // Write/fence response FIFO entry; fences share the FIFO so they stay ordered behind writes
  typedef struct packed {
    t_ccip_vc    vc;
    logic        isFence;
    t_ccip_mdata mdata;
  } t_c1RspEntry;

  // The host picks a physical channel when the AFU asks for "any"; this model always picks VL0
  function automatic t_ccip_vc usedVc(input t_ccip_vc sel);
    return (sel == eVC_VA) ? eVC_VL0 : sel;
  endfunction

endpackage

// File: rtl/ccip_host_mem_rsp_fifo.sv
// rtl/ccip_host_mem_rsp_fifo.sv - in-order response FIFO with registered occupancy
module ccip_host_mem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pushValid,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign doPop   = pop && (count != '0);
  assign doPush  = pushValid && ((count != FULL_CNT) || doPop);
  assign popData = store[rdPtr];
  assign empty   = (count == '0);

  // Entry storage; no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (doPush) begin
      store[wrPtr] <= pushData;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PTR_W'(doPush);
      rdPtr <= rdPtr + PTR_W'(doPop);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

endmodule

// File: rtl/ccip_host_mem_model.sv
// rtl/ccip_host_mem_model.sv - behavioural CCI-P host memory with fixed-latency, back-pressured responses
module ccip_host_mem_model
  import ccip_host_mem_model_pkg::*;
#(
  parameter int ADDR_BITS      = DEFAULT_ADDR_BITS,
  parameter int RSP_FIFO_DEPTH = DEFAULT_RSP_FIFO_DEPTH,
  parameter int ALMFULL_SLACK  = DEFAULT_ALMFULL_SLACK
) (
  input  logic           clk,
  input  logic           reset,
  input  t_if_ccip_c0_Tx c0Tx,
  input  t_if_ccip_c1_Tx c1Tx,
  output logic           c0TxAlmFull,
  output logic           c1TxAlmFull,
  output t_if_ccip_c0_Rx c0Rx,
  output t_if_ccip_c1_Rx c1Rx,
  input  logic           stall_rsp,
  output logic           overflow_err
);

  localparam int LINES = 1 << ADDR_BITS;
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(RSP_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALM_LVL  = CNT_W'(RSP_FIFO_DEPTH - ALMFULL_SLACK);

  t_ccip_clData lineMem [LINES];

  logic [ADDR_BITS-1:0] c0Idx;
  logic [ADDR_BITS-1:0] c1Idx;
  logic                 c0IsRead;
  logic                 c1IsWrite;
  logic                 c1IsFence;
  logic                 c0Room;
  logic                 c1Room;
  logic                 c0Accept;
  logic                 c1Accept;
  logic                 c0Drop;
  logic                 c1Drop;
  logic                 badLen;
  logic                 c0Pop;
  logic                 c1Pop;
  logic [CNT_W-1:0]     c0Occ;
  logic [CNT_W-1:0]     c1Occ;
  logic [CNT_W-1:0]     c0FifoCount;
  logic [CNT_W-1:0]     c1FifoCount;
  logic                 c0FifoEmpty;
  logic                 c1FifoEmpty;
  logic                 unusedAddrBits;

  logic         c0S1Valid;
  t_ccip_vc     c0S1Vc;
  t_ccip_mdata  c0S1Mdata;
  t_ccip_clData c0S1Data;
  logic         c0S2Valid;
  t_ccip_vc     c0S2Vc;
  t_ccip_mdata  c0S2Mdata;
  t_ccip_clData c0S2Data;
  logic         c1S1Valid;
  t_c1RspEntry  c1S1Entry;

  t_c0RspEntry  c0PushEntry;
  t_c0RspEntry  c0Head;
  t_c1RspEntry  c1Head;

  assign c0Idx = c0Tx.hdr.address[ADDR_BITS-1:0];
  assign c1Idx = c1Tx.hdr.address[ADDR_BITS-1:0];
  assign unusedAddrBits = ^{c0Tx.hdr.address[CCIP_ADDR_W-1:ADDR_BITS],
                            c1Tx.hdr.address[CCIP_ADDR_W-1:ADDR_BITS]};

  assign c0IsRead  = c0Tx.valid && ((c0Tx.hdr.req_type == eREQ_RDLINE_I) ||
                                    (c0Tx.hdr.req_type == eREQ_RDLINE_S));
  assign c1IsWrite = c1Tx.valid && ((c1Tx.hdr.req_type == eREQ_WRLINE_I) ||
                                    (c1Tx.hdr.req_type == eREQ_WRLINE_M));
  assign c1IsFence = c1Tx.valid && (c1Tx.hdr.req_type == eREQ_WRFENCE);

  // Occupancy covers responses still in the pipeline so an accepted request always has a FIFO slot
  assign c0Occ = c0FifoCount + CNT_W'(c0S1Valid) + CNT_W'(c0S2Valid);
  assign c1Occ = c1FifoCount + CNT_W'(c1S1Valid);

  assign c0Pop = !reset && !stall_rsp && !c0FifoEmpty;
  assign c1Pop = !reset && !stall_rsp && !c1FifoEmpty;

  // At full, a departing head frees exactly the slot the new request will need
  assign c0Room   = (c0Occ < FULL_LVL) || c0Pop;
  assign c1Room   = (c1Occ < FULL_LVL) || c1Pop;
  assign c0Accept = !reset && c0IsRead && c0Room;
  assign c1Accept = !reset && (c1IsWrite || c1IsFence) && c1Room;
  assign c0Drop   = !reset && c0IsRead && !c0Room;
  assign c1Drop   = !reset && (c1IsWrite || c1IsFence) && !c1Room;
  assign badLen   = (c0Accept && (c0Tx.hdr.cl_len != eCL_LEN_1)) ||
                    (c1Accept && c1IsWrite && (c1Tx.hdr.cl_len != eCL_LEN_1));

  // Backing store; writes land in the acceptance cycle and reset never touches contents
  always_ff @(posedge clk) begin
    if (c1Accept && c1IsWrite) begin
      lineMem[c1Idx] <= c1Tx.data;
    end
  end

  // Read pipeline: stage 1 samples the line before any same-cycle write lands, stage 2 feeds the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      c0S1Valid <= 1'b0;
      c0S2Valid <= 1'b0;
    end else begin
      c0S1Valid <= c0Accept;
      c0S2Valid <= c0S1Valid;
    end
    c0S1Vc    <= usedVc(c0Tx.hdr.vc_sel);
    c0S1Mdata <= c0Tx.hdr.mdata;
    c0S1Data  <= lineMem[c0Idx];
    c0S2Vc    <= c0S1Vc;
    c0S2Mdata <= c0S1Mdata;
    c0S2Data  <= c0S1Data;
  end

  // Write/fence pipeline: one stage, then into the c1 FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      c1S1Valid <= 1'b0;
    end else begin
      c1S1Valid <= c1Accept;
    end
    c1S1Entry.vc      <= usedVc(c1Tx.hdr.vc_sel);
    c1S1Entry.isFence <= c1IsFence;
    c1S1Entry.mdata   <= c1Tx.hdr.mdata;
  end

  assign c0PushEntry = '{vc: c0S2Vc, mdata: c0S2Mdata, data: c0S2Data};

  ccip_host_mem_rsp_fifo #(
    .WIDTH($bits(t_c0RspEntry)),
    .DEPTH(RSP_FIFO_DEPTH)
  ) u_c0Fifo (
    .clk      (clk),
    .reset    (reset),
    .pushValid(c0S2Valid),
    .pushData (c0PushEntry),
    .pop      (c0Pop),
    .popData  (c0Head),
    .count    (c0FifoCount),
    .empty    (c0FifoEmpty)
  );

  ccip_host_mem_rsp_fifo #(
    .WIDTH($bits(t_c1RspEntry)),
    .DEPTH(RSP_FIFO_DEPTH)
  ) u_c1Fifo (
    .clk      (clk),
    .reset    (reset),
    .pushValid(c1S1Valid),
    .pushData (c1S1Entry),
    .pop      (c1Pop),
    .popData  (c1Head),
    .count    (c1FifoCount),
    .empty    (c1FifoEmpty)
  );

  // Registered Rx outputs: rspValid is high only in the cycle following a pop
  always_ff @(posedge clk) begin
    if (reset) begin
      c0Rx <= '0;
      c1Rx <= '0;
    end else begin
      c0Rx.rspValid    <= c0Pop;
      c0Rx.mmioRdValid <= 1'b0;
      c0Rx.mmioWrValid <= 1'b0;
      if (c0Pop) begin
        c0Rx.hdr.vc_used   <= c0Head.vc;
        c0Rx.hdr.hit_miss  <= 1'b0;
        c0Rx.hdr.cl_num    <= 2'b00;
        c0Rx.hdr.resp_type <= eRSP_RDLINE;
        c0Rx.hdr.mdata     <= c0Head.mdata;
        c0Rx.data          <= c0Head.data;
      end
      c1Rx.rspValid <= c1Pop;
      if (c1Pop) begin
        c1Rx.hdr.vc_used   <= c1Head.vc;
        c1Rx.hdr.hit_miss  <= 1'b0;
        c1Rx.hdr.format    <= 1'b0;
        c1Rx.hdr.cl_num    <= 2'b00;
        c1Rx.hdr.resp_type <= c1Head.isFence ? eRSP_WRFENCE : eRSP_WRLINE;
        c1Rx.hdr.mdata     <= c1Head.mdata;
      end
    end
  end

  // Back-pressure and sticky error flag; almost-full holds high through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      c0TxAlmFull  <= 1'b1;
      c1TxAlmFull  <= 1'b1;
      overflow_err <= 1'b0;
    end else begin
      c0TxAlmFull <= (c0Occ >= ALM_LVL);
      c1TxAlmFull <= (c1Occ >= ALM_LVL);
      if (c0Drop || c1Drop || badLen) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccip_host_mem_model.sv
// tb/tb_ccip_host_mem_model.sv - directed self-checking bench for ccip_host_mem_model
module tb_ccip_host_mem_model;
  import ccip_host_mem_model_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  t_if_ccip_c0_Tx c0Tx;
  t_if_ccip_c1_Tx c1Tx;
  logic           c0TxAlmFull;
  logic           c1TxAlmFull;
  t_if_ccip_c0_Rx c0Rx;
  t_if_ccip_c1_Rx c1Rx;
  logic           stall_rsp;
  logic           overflow_err;

  int errCount = 0;
  int chkCount = 0;

  typedef struct {
    bit          isWr;
    logic [41:0] addr;
    logic [15:0] mdata;
    t_ccip_vc    vc;
    logic [7:0]  wByte;
    logic [7:0]  expByte;
    t_ccip_vc    expVc;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  ccip_host_mem_model dut (
    .clk         (clk),
    .reset       (reset),
    .c0Tx        (c0Tx),
    .c1Tx        (c1Tx),
    .c0TxAlmFull (c0TxAlmFull),
    .c1TxAlmFull (c1TxAlmFull),
    .c0Rx        (c0Rx),
    .c1Rx        (c1Rx),
    .stall_rsp   (stall_rsp),
    .overflow_err(overflow_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chkCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic driveRd(input logic [41:0] a, input logic [15:0] m, input t_ccip_vc vc,
                         input t_ccip_clLen len);
    @(negedge clk);
    c0Tx.valid        = 1'b1;
    c0Tx.hdr.vc_sel   = vc;
    c0Tx.hdr.cl_len   = len;
    c0Tx.hdr.req_type = eREQ_RDLINE_S;
    c0Tx.hdr.address  = a;
    c0Tx.hdr.mdata    = m;
    @(posedge clk);
    #1 c0Tx.valid = 1'b0;
  endtask

  task automatic driveWr(input logic [41:0] a, input logic [15:0] m, input t_ccip_vc vc,
                         input logic [7:0] b);
    @(negedge clk);
    c1Tx.valid        = 1'b1;
    c1Tx.hdr.vc_sel   = vc;
    c1Tx.hdr.cl_len   = eCL_LEN_1;
    c1Tx.hdr.req_type = eREQ_WRLINE_I;
    c1Tx.hdr.address  = a;
    c1Tx.hdr.mdata    = m;
    c1Tx.data         = {64{b}};
    @(posedge clk);
    #1 c1Tx.valid = 1'b0;
  endtask

  task automatic driveFence(input logic [15:0] m);
    @(negedge clk);
    c1Tx.valid        = 1'b1;
    c1Tx.hdr.vc_sel   = eVC_VA;
    c1Tx.hdr.cl_len   = eCL_LEN_1;
    c1Tx.hdr.req_type = eREQ_WRFENCE;
    c1Tx.hdr.address  = '0;
    c1Tx.hdr.mdata    = m;
    @(posedge clk);
    #1 c1Tx.valid = 1'b0;
  endtask

  task automatic waitC0(output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (c0Rx.rspValid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic waitC1(output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (c1Rx.rspValid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic chkLine(input string name, input logic [511:0] act, input logic [7:0] b);
    logic [511:0] exp;
    exp = {64{b}};
    chk({name, "_lo"}, act[63:0], exp[63:0]);
    chk({name, "_hi"}, act[511:448], exp[511:448]);
  endtask

  initial begin
    int lat;
    int badOrder;
    int nRsp;
    logic [15:0] qMdata[$];
    int          qCyc[$];
    t_ccip_c1_rsp qType[$];
    logic [15:0] expFenceMd[4];
    t_ccip_c1_rsp expFenceTy[4];

    reset     = 1'b1;
    stall_rsp = 1'b0;
    c0Tx      = '0;
    c1Tx      = '0;

    vecs[0] = '{1'b1, 42'h010, 16'h0003, eVC_VA,  8'hA5, 8'h00, eVC_VL0};
    vecs[1] = '{1'b0, 42'h010, 16'h0004, eVC_VH0, 8'h00, 8'hA5, eVC_VH0};
    vecs[2] = '{1'b1, 42'h020, 16'h0005, eVC_VL0, 8'h11, 8'h00, eVC_VL0};
    vecs[3] = '{1'b0, 42'h020, 16'h0006, eVC_VA,  8'h00, 8'h11, eVC_VL0};
    vecs[4] = '{1'b1, 42'h3FF, 16'hFFFF, eVC_VH1, 8'h5A, 8'h00, eVC_VH1};
    vecs[5] = '{1'b0, 42'h3FF, 16'hBEEF, eVC_VH1, 8'h00, 8'h5A, eVC_VH1};
    vecs[6] = '{1'b1, 42'h000, 16'h0001, eVC_VL0, 8'h77, 8'h00, eVC_VL0};
    vecs[7] = '{1'b0, 42'h400, 16'h0002, eVC_VA,  8'h00, 8'h77, eVC_VL0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c0AlmFull", 64'(c0TxAlmFull), 64'd1);
    chk("rst_c1AlmFull", 64'(c1TxAlmFull), 64'd1);
    chk("rst_c0RspValid", 64'(c0Rx.rspValid), 64'd0);
    chk("rst_c1RspValid", 64'(c1Rx.rspValid), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_c0AlmFull", 64'(c0TxAlmFull), 64'd0);
    chk("rel_c1AlmFull", 64'(c1TxAlmFull), 64'd0);

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].isWr) begin
        driveWr(vecs[i].addr, vecs[i].mdata, vecs[i].vc, vecs[i].wByte);
        waitC1(lat);
        chk($sformatf("v%0d_wr_lat", i), 64'(lat), 64'd2);
        chk($sformatf("v%0d_wr_mdata", i), 64'(c1Rx.hdr.mdata), 64'(vecs[i].mdata));
        chk($sformatf("v%0d_wr_type", i), 64'(c1Rx.hdr.resp_type), 64'(eRSP_WRLINE));
        chk($sformatf("v%0d_wr_vc", i), 64'(c1Rx.hdr.vc_used), 64'(vecs[i].expVc));
      end else begin
        driveRd(vecs[i].addr, vecs[i].mdata, vecs[i].vc, eCL_LEN_1);
        waitC0(lat);
        chk($sformatf("v%0d_rd_lat", i), 64'(lat), 64'd3);
        chk($sformatf("v%0d_rd_mdata", i), 64'(c0Rx.hdr.mdata), 64'(vecs[i].mdata));
        chk($sformatf("v%0d_rd_type", i), 64'(c0Rx.hdr.resp_type), 64'(eRSP_RDLINE));
        chk($sformatf("v%0d_rd_vc", i), 64'(c0Rx.hdr.vc_used), 64'(vecs[i].expVc));
        chkLine($sformatf("v%0d_rd_data", i), c0Rx.data, vecs[i].expByte);
        chk($sformatf("v%0d_mmio", i), 64'({c0Rx.mmioRdValid, c0Rx.mmioWrValid}), 64'd0);
      end
      repeat (2) @(posedge clk);
    end

    // Same-cycle read and write of line 0x20 (holds 0x11): the read sees the old line
    @(negedge clk);
    c0Tx.valid        = 1'b1;
    c0Tx.hdr.vc_sel   = eVC_VL0;
    c0Tx.hdr.cl_len   = eCL_LEN_1;
    c0Tx.hdr.req_type = eREQ_RDLINE_I;
    c0Tx.hdr.address  = 42'h020;
    c0Tx.hdr.mdata    = 16'h0021;
    c1Tx.valid        = 1'b1;
    c1Tx.hdr.vc_sel   = eVC_VL0;
    c1Tx.hdr.cl_len   = eCL_LEN_1;
    c1Tx.hdr.req_type = eREQ_WRLINE_M;
    c1Tx.hdr.address  = 42'h020;
    c1Tx.hdr.mdata    = 16'h0022;
    c1Tx.data         = {64{8'h55}};
    @(posedge clk);
    #1;
    c0Tx.valid = 1'b0;
    c1Tx.valid = 1'b0;
    waitC0(lat);
    chk("rbw_lat", 64'(lat), 64'd3);
    chkLine("rbw_old", c0Rx.data, 8'h11);
    repeat (2) @(posedge clk);
    driveRd(42'h020, 16'h0023, eVC_VL0, eCL_LEN_1);
    waitC0(lat);
    chkLine("rbw_new", c0Rx.data, 8'h55);
    repeat (3) @(posedge clk);

    // Three writes then a fence while responses are stalled
    @(negedge clk);
    stall_rsp = 1'b1;
    for (int i = 0; i < 3; i++) driveWr(42'h030 + 42'(i), 16'(i + 1), eVC_VA, 8'hC0 + 8'(i));
    driveFence(16'h0007);
    repeat (5) @(posedge clk);
    #1;
    chk("fence_stalled", 64'(c1Rx.rspValid), 64'd0);
    @(negedge clk);
    stall_rsp = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #1;
      if (c1Rx.rspValid) begin
        qMdata.push_back(c1Rx.hdr.mdata);
        qType.push_back(c1Rx.hdr.resp_type);
        qCyc.push_back(cyc);
      end
    end
    expFenceMd = '{16'h1, 16'h2, 16'h3, 16'h7};
    expFenceTy = '{eRSP_WRLINE, eRSP_WRLINE, eRSP_WRLINE, eRSP_WRFENCE};
    chk("fence_count", 64'(qMdata.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < qMdata.size()) begin
        chk($sformatf("fence_md%0d", i), 64'(qMdata[i]), 64'(expFenceMd[i]));
        chk($sformatf("fence_ty%0d", i), 64'(qType[i]), 64'(expFenceTy[i]));
      end
    end
    if (qCyc.size() == 4) chk("fence_consec", 64'(qCyc[3] - qCyc[0]), 64'd3);
    qMdata.delete();
    qType.delete();
    qCyc.delete();

    // 24 stalled reads reach the almost-full threshold; release drains them in order
    chk("pre24_almFull", 64'(c0TxAlmFull), 64'd0);
    @(negedge clk);
    stall_rsp = 1'b1;
    for (int i = 0; i < 24; i++) driveRd(42'h010, 16'(i), eVC_VL0, eCL_LEN_1);
    @(posedge clk);
    #1;
    chk("s24_almFull", 64'(c0TxAlmFull), 64'd1);
    chk("s24_noRsp", 64'(c0Rx.rspValid), 64'd0);
    @(negedge clk);
    stall_rsp = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (c0Rx.rspValid) begin
        qMdata.push_back(c0Rx.hdr.mdata);
        qCyc.push_back(cyc);
      end
    end
    chk("s24_count", 64'(qMdata.size()), 64'd24);
    badOrder = 0;
    for (int i = 0; i < qMdata.size(); i++) begin
      if (qMdata[i] != 16'(i) || qCyc[i] != qCyc[0] + i) badOrder++;
    end
    chk("s24_order", 64'(badOrder), 64'd0);
    chk("s24_drained_almFull", 64'(c0TxAlmFull), 64'd0);
    qMdata.delete();
    qCyc.delete();

    // 33 stalled reads: the last one is dropped and flagged
    chk("pre33_overflow", 64'(overflow_err), 64'd0);
    @(negedge clk);
    stall_rsp = 1'b1;
    for (int i = 0; i < 33; i++) driveRd(42'h010, 16'h100 + 16'(i), eVC_VL0, eCL_LEN_1);
    chk("s33_overflow", 64'(overflow_err), 64'd1);
    @(negedge clk);
    stall_rsp = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1;
      if (c0Rx.rspValid) qMdata.push_back(c0Rx.hdr.mdata);
    end
    chk("s33_count", 64'(qMdata.size()), 64'd32);
    badOrder = 0;
    for (int i = 0; i < qMdata.size(); i++) begin
      if (qMdata[i] != 16'h100 + 16'(i)) badOrder++;
    end
    chk("s33_order", 64'(badOrder), 64'd0);
    chk("s33_sticky", 64'(overflow_err), 64'd1);
    qMdata.delete();

    // Reset with reads in flight and a write presented during reset
    for (int i = 0; i < 4; i++) driveRd(42'h010, 16'h200 + 16'(i), eVC_VA, eCL_LEN_1);
    @(negedge clk);
    reset             = 1'b1;
    c1Tx.valid        = 1'b1;
    c1Tx.hdr.vc_sel   = eVC_VA;
    c1Tx.hdr.cl_len   = eCL_LEN_1;
    c1Tx.hdr.req_type = eREQ_WRLINE_I;
    c1Tx.hdr.address  = 42'h010;
    c1Tx.hdr.mdata    = 16'h0300;
    c1Tx.data         = {64{8'hEE}};
    @(posedge clk);
    #1;
    chk("mid_rst_c0RspValid", 64'(c0Rx.rspValid), 64'd0);
    chk("mid_rst_c1RspValid", 64'(c1Rx.rspValid), 64'd0);
    chk("mid_rst_c0AlmFull", 64'(c0TxAlmFull), 64'd1);
    chk("mid_rst_c1AlmFull", 64'(c1TxAlmFull), 64'd1);
    chk("mid_rst_overflow", 64'(overflow_err), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    c1Tx.valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_c0AlmFull", 64'(c0TxAlmFull), 64'd0);
    chk("post_rst_c1AlmFull", 64'(c1TxAlmFull), 64'd0);
    nRsp = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk);
      #1;
      if (c0Rx.rspValid || c1Rx.rspValid) nRsp++;
    end
    chk("post_rst_noRsp", 64'(nRsp), 64'd0);
    driveRd(42'h010, 16'h0400, eVC_VA, eCL_LEN_1);
    waitC0(lat);
    chk("post_rst_rd_lat", 64'(lat), 64'd3);
    chkLine("post_rst_mem", c0Rx.data, 8'hA5);
    repeat (2) @(posedge clk);

    // Unsupported length is served as one line and flagged
    driveRd(42'h020, 16'h0500, eVC_VH0, eCL_LEN_2);
    waitC0(lat);
    chk("len2_lat", 64'(lat), 64'd3);
    chk("len2_mdata", 64'(c0Rx.hdr.mdata), 64'h500);
    chkLine("len2_data", c0Rx.data, 8'h55);
    chk("len2_overflow", 64'(overflow_err), 64'd1);

    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule

// File: doc/ccip_host_mem_model.md
CCIP_HOST_MEM_MODEL -- requirements
Module: ccip_host_mem_model

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning log2 of backing lines (512 b each), indexed by request address[ADDR_BITS-1:0].
REQ-002 SHALL have parameter RSP_FIFO_DEPTH, default 32, meaning entries per response FIFO (power of 2, at least 16).
REQ-003 SHALL have parameter ALMFULL_SLACK, default 8, meaning free entries still guaranteed when almost-full asserts.
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port c0Tx, input, t_if_ccip_c0_Tx, meaning read requests from the AFU side.
REQ-007 SHALL have port c1Tx, input, t_if_ccip_c1_Tx, meaning write and WrFence requests.
REQ-008 SHALL have port c0TxAlmFull, output, 1, meaning read-channel back-pressure.
REQ-009 SHALL have port c1TxAlmFull, output, 1, meaning write-channel back-pressure.
REQ-010 SHALL have port c0Rx, output, t_if_ccip_c0_Rx, meaning read responses.
REQ-011 SHALL have port c1Rx, output, t_if_ccip_c1_Rx, meaning write and fence responses.
REQ-012 SHALL have port stall_rsp, input, 1, meaning hold all Rx responses this cycle (host-latency injection).
REQ-013 SHALL have port overflow_err, output, 1, meaning sticky flag for a request lost to a full FIFO.

Function
REQ-014 SHALL accept c0Tx when c0Tx.valid and hdr.req_type=eREQ_RDLINE_I/S, and read the line at the indexed address.
REQ-015 SHALL accept c1Tx eREQ_WRLINE_I/M and write c1Tx.data to the indexed line in the acceptance cycle.
REQ-016 SHALL return old data for a read and write to the same line accepted in the same cycle (read-before-write).
REQ-017 SHALL support only cl_len=eCL_LEN_1; other lengths SHALL be treated as length 1 and SHALL set overflow_err.
REQ-018 SHALL push each read response (mdata echoed, vc_used=hdr.vc_sel or eVC_VL0 if eVC_VA, resp_type=eRSP_RDLINE, data) into the c0 FIFO exactly 2 cycles after acceptance.
REQ-019 SHALL push each write response (resp_type=eRSP_WRLINE, format=0, cl_num=0, mdata echoed) into the c1 FIFO 1 cycle after acceptance.
REQ-020 SHALL accept eREQ_WRFENCE without a memory write and SHALL respond with eRSP_WRFENCE only after every earlier c1 response has left the FIFO.
REQ-021 SHALL pop at most one entry per FIFO per cycle while stall_rsp=0, and drive c*Rx.rspValid for exactly that cycle; with stall_rsp=1 no rspValid SHALL assert.
REQ-022 SHALL drive minimum response latency of 3 cycles (c0) and 2 cycles (c1) from request to rspValid, each FIFO in order.
REQ-023 SHALL count occupancy as FIFO entries plus in-flight pipeline entries, per channel.
REQ-024 SHALL register almost-full: c*TxAlmFull=1 when occupancy >= RSP_FIFO_DEPTH-ALMFULL_SLACK.
REQ-025 SHALL drop a request arriving when occupancy = RSP_FIFO_DEPTH and set overflow_err until reset.
REQ-026 SHALL handle simultaneous push and pop on one FIFO with occupancy unchanged, including at full.
REQ-027 SHALL keep c0Rx.mmioRdValid, c0Rx.mmioWrValid and all unused Rx fields at 0.

Reset
REQ-028 SHALL, during reset, drive c0TxAlmFull=1, c1TxAlmFull=1, all rspValid=0, overflow_err=0, and empty FIFOs and pipelines.
REQ-029 SHALL discard requests presented during reset and in-flight responses when reset asserts mid-operation.
REQ-030 SHALL leave backing memory contents unchanged by reset.

Structure
REQ-031 SHALL place response-FIFO entry typedefs and default constants in package ccip_host_mem_model_pkg.
REQ-032 SHALL use one sub-module, ccip_host_mem_rsp_fifo (parameterised width and depth, registered occupancy), instantiated per channel.

Verification
REQ-033 SHALL cover write 0xA5-pattern to addr 0x10 with mdata 0x3 -> c1Rx eRSP_WRLINE mdata 0x3 at +2; then read 0x10 -> c0Rx data 0xA5-pattern at +3.
REQ-034 SHALL cover same-cycle write 0x55 and read of addr 0x20 holding 0x11 -> read returns 0x11.
REQ-035 SHALL cover stall_rsp=1 with 24 reads issued -> c0TxAlmFull=1 after occupancy 24; release -> 24 in-order responses on consecutive cycles.
REQ-036 SHALL cover 33 reads during stall -> overflow_err=1, exactly 32 responses after release.
REQ-037 SHALL cover 3 writes, then WrFence mdata 0x7, with stall held 5 cycles -> fence response after the 3 write responses.
REQ-038 SHALL cover reset asserted with 4 reads in flight -> no rspValid afterward; almFull=1 in reset, 0 one cycle after release.
